// File: rtl/stream_out.sv
// Output stage of the up-sampling path: re-serialises the column blocks owned by the
// N_PARALLEL up-sampling elements into one raster-order AXI-Stream via a 2-entry skid buffer.
module stream_out #(
  parameter int AXISOUT_DATA_WIDTH = 32,
  parameter int UPSP_WRTDATA_WIDTH = 32,
  parameter int DST_IMG_WIDTH      = 3840,
  parameter int DST_IMG_HEIGHT     = 2160,
  parameter int N_PARALLEL         = 2
) (
  input  logic                                   m_axis_aclk,
  input  logic                                   m_axis_arst,
  input  logic                                   UPSTART,
  output logic                                   OUTEND,
  input  logic [N_PARALLEL-1:0]                  upsp_ac_wvalid,
  output logic [N_PARALLEL-1:0]                  ac_upsp_wready,
  input  logic [N_PARALLEL*UPSP_WRTDATA_WIDTH-1:0] upsp_ac_wdata,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic [AXISOUT_DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [AXISOUT_DATA_WIDTH/8-1:0]        m_axis_tstrb,
  output logic [AXISOUT_DATA_WIDTH/8-1:0]        m_axis_tkeep,
  output logic                                   m_axis_tlast,
  output logic                                   m_axis_tuser,
  output logic                                   m_axis_tid,
  output logic                                   m_axis_tdest,
  output logic [1:0]                             dbg_state
);

  localparam int DW    = AXISOUT_DATA_WIDTH;
  localparam int SW    = AXISOUT_DATA_WIDTH / 8;
  localparam int BLOCK = DST_IMG_WIDTH / N_PARALLEL;
  localparam int COL_W = (DST_IMG_WIDTH > 1) ? $clog2(DST_IMG_WIDTH) : 1;
  localparam int ROW_W = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
  localparam int SEL_W = (N_PARALLEL > 1) ? $clog2(N_PARALLEL) : 1;

  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(DST_IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(DST_IMG_HEIGHT - 1);
  localparam logic [31:0]      BLOCK_U    = 32'(BLOCK);
  localparam logic [SW-1:0]    STRB_CONST = SW'(3'b111);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic          tuser;
    logic          tlast;
    logic [DW-1:0] data;
  } beat_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [1:0]       count;
  beat_t            head;
  beat_t            tail;

  logic [SEL_W-1:0] sel;
  logic [DW-1:0]    sel_data;
  logic             sel_valid;
  logic             push;
  logic             pop;
  beat_t            push_beat;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // wready is derived only from registered state/count (never from m_axis_tready), and
  // m_axis_tvalid, once high, holds with a stable head entry until it is taken.
  always_comb begin
    sel       = SEL_W'(32'(col) / BLOCK_U);
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int j = 0; j < N_PARALLEL; j++) begin
      ac_upsp_wready[j] = (state == ACTIVE) && (sel == SEL_W'(j)) && (count != 2'd2);
      if (sel == SEL_W'(j)) begin
        sel_data  = upsp_ac_wdata[j*UPSP_WRTDATA_WIDTH +: DW];
        sel_valid = upsp_ac_wvalid[j];
      end
    end
    push            = sel_valid && (state == ACTIVE) && (count != 2'd2);
    pop             = m_axis_tvalid && m_axis_tready;
    push_beat.tuser = (row == '0) && (col == '0);
    push_beat.tlast = (col == COL_LAST);
    push_beat.data  = sel_data;
    // The frame is over once the last buffered beat leaves during DRAIN.
    OUTEND          = (state == DRAIN) && pop && (count == 2'd1);
  end

  always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
    if (m_axis_arst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (UPSTART) begin
            state <= ACTIVE;
            col   <= '0;
            row   <= '0;
          end
        end
        ACTIVE: begin
          if (push) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row   <= '0;
                state <= DRAIN;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (OUTEND) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Skid buffer: head always drives the outputs; tail only fills when head is stuck.
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_beat;
          else               tail <= push_beat;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_beat;
          end else begin
            head <= tail;
            tail <= push_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tvalid = (count != 2'd0);
  assign m_axis_tdata  = head.data;
  assign m_axis_tlast  = head.tlast;
  assign m_axis_tuser  = head.tuser;
  assign m_axis_tstrb  = STRB_CONST;
  assign m_axis_tkeep  = STRB_CONST;
  assign m_axis_tid    = 1'b0;
  assign m_axis_tdest  = 1'b0;
  assign dbg_state     = state;

endmodule

// File: tb/tb_stream_out.sv
// Directed bench for stream_out: an 8x2 frame over two elements (dut_a) and a 4x2 frame
// over a single element (dut_b), checked against hand-built expected beat queues.
module tb_stream_out;

  typedef logic [33:0] beat_t; // {tuser, tlast, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- dut_a: W=8, H=2, N=2 ----------------
  logic        a_upstart, a_outend, a_tvalid, a_tready, a_tlast, a_tuser, a_tid, a_tdest;
  logic [1:0]  a_wvalid, a_wready, a_state, a_en;
  logic [63:0] a_wdata;
  logic [31:0] a_tdata;
  logic [3:0]  a_tstrb, a_tkeep;

  stream_out #(
    .AXISOUT_DATA_WIDTH(32), .UPSP_WRTDATA_WIDTH(32),
    .DST_IMG_WIDTH(8), .DST_IMG_HEIGHT(2), .N_PARALLEL(2)
  ) dut_a (
    .m_axis_aclk(clk), .m_axis_arst(rst), .UPSTART(a_upstart), .OUTEND(a_outend),
    .upsp_ac_wvalid(a_wvalid), .ac_upsp_wready(a_wready), .upsp_ac_wdata(a_wdata),
    .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready), .m_axis_tdata(a_tdata),
    .m_axis_tstrb(a_tstrb), .m_axis_tkeep(a_tkeep), .m_axis_tlast(a_tlast),
    .m_axis_tuser(a_tuser), .m_axis_tid(a_tid), .m_axis_tdest(a_tdest),
    .dbg_state(a_state)
  );

  // ---------------- dut_b: W=4, H=2, N=1 ----------------
  logic        b_upstart, b_outend, b_tvalid, b_tready, b_tlast, b_tuser, b_tid, b_tdest;
  logic [0:0]  b_wvalid, b_wready;
  logic        b_en;
  logic [1:0]  b_state;
  logic [31:0] b_wdata, b_tdata;
  logic [3:0]  b_tstrb, b_tkeep;

  stream_out #(
    .AXISOUT_DATA_WIDTH(32), .UPSP_WRTDATA_WIDTH(32),
    .DST_IMG_WIDTH(4), .DST_IMG_HEIGHT(2), .N_PARALLEL(1)
  ) dut_b (
    .m_axis_aclk(clk), .m_axis_arst(rst), .UPSTART(b_upstart), .OUTEND(b_outend),
    .upsp_ac_wvalid(b_wvalid), .ac_upsp_wready(b_wready), .upsp_ac_wdata(b_wdata),
    .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready), .m_axis_tdata(b_tdata),
    .m_axis_tstrb(b_tstrb), .m_axis_tkeep(b_tkeep), .m_axis_tlast(b_tlast),
    .m_axis_tuser(b_tuser), .m_axis_tid(b_tid), .m_axis_tdest(b_tdest),
    .dbg_state(b_state)
  );

  // ---------------- up-sampling element models ----------------
  // Element j of dut_a owns columns 4j..4j+3 and emits col+8*row for its block in order.
  logic        el_clr;
  int unsigned a_cnt [2];
  int unsigned b_cnt;

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (el_clr) a_cnt[j] <= 0;
      else if (a_wvalid[j] && a_wready[j]) a_cnt[j] <= a_cnt[j] + 1;
    end
    if (el_clr) b_cnt <= 0;
    else if (b_wvalid[0] && b_wready[0]) b_cnt <= b_cnt + 1;
  end

  for (genvar j = 0; j < 2; j++) begin : g_el
    assign a_wdata[j*32 +: 32] = 32'(j*4) + 32'(a_cnt[j] % 4) + 32'(8 * (a_cnt[j] / 4));
  end
  assign a_wvalid    = a_en;
  assign b_wvalid[0] = b_en;
  assign b_wdata     = 32'(b_cnt);

  // ---------------- scoreboard ----------------
  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t exp_a[$];
  beat_t exp_b[$];
  int    beats_a, beats_b, outend_a, outend_b;
  logic  stall_a = 1'b0, stall_b = 1'b0;
  beat_t held_a, held_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_a = 1'b0;
      stall_b = 1'b0;
    end else begin
      if (stall_a) begin
        check("a_hold_valid", a_tvalid, 1);
        check("a_hold_beat", {a_tuser, a_tlast, a_tdata}, held_a);
      end
      if (a_outend) outend_a++;
      if (a_tvalid && a_tready) begin
        check("a_q_nonempty", exp_a.size() != 0, 1);
        if (exp_a.size() != 0) check("a_beat", {a_tuser, a_tlast, a_tdata}, exp_a.pop_front());
        check("a_outend_at_beat", a_outend, beats_a == 15);
        beats_a++;
      end
      stall_a = a_tvalid && !a_tready;
      held_a  = {a_tuser, a_tlast, a_tdata};

      if (stall_b) begin
        check("b_hold_valid", b_tvalid, 1);
        check("b_hold_beat", {b_tuser, b_tlast, b_tdata}, held_b);
      end
      if (b_outend) outend_b++;
      if (b_tvalid && b_tready) begin
        check("b_q_nonempty", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) check("b_beat", {b_tuser, b_tlast, b_tdata}, exp_b.pop_front());
        check("b_outend_at_beat", b_outend, beats_b == 7);
        beats_b++;
      end
      stall_b = b_tvalid && !b_tready;
      held_b  = {b_tuser, b_tlast, b_tdata};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 16 beats of data 0..15; tlast closes each 8-pixel row, tuser marks the frame start.
  task automatic load_frame_a();
    for (int i = 0; i < 16; i++) exp_a.push_back({i == 0, (i % 8) == 7, 32'(i)});
  endtask

  task automatic load_frame_b();
    for (int i = 0; i < 8; i++) exp_b.push_back({i == 0, (i % 4) == 3, 32'(i)});
  endtask

  task automatic start_a();
    beats_a  = 0;
    outend_a = 0;
    el_clr = 1'b1; tick(); el_clr = 1'b0;
    a_upstart = 1'b1; tick(); a_upstart = 1'b0;
  endtask

  task automatic start_b();
    beats_b  = 0;
    outend_b = 0;
    el_clr = 1'b1; tick(); el_clr = 1'b0;
    b_upstart = 1'b1; tick(); b_upstart = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget, output int n);
    n = 0;
    while ((exp_a.size() != 0 || a_state != 2'd0) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, exp_a.size() == 0 && a_state == 2'd0, 1);
    check({tag, "_outend_cnt"}, outend_a, 1);
    check({tag, "_idle_tvalid"}, a_tvalid, 0);
  endtask

  task automatic wait_done_b(input string tag, input int budget, output int n);
    n = 0;
    while ((exp_b.size() != 0 || b_state != 2'd0) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, exp_b.size() == 0 && b_state == 2'd0, 1);
    check({tag, "_outend_cnt"}, outend_b, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1;
    a_upstart = 1'b0; a_en = 2'b00; a_tready = 1'b0;
    b_upstart = 1'b0; b_en = 1'b0;  b_tready = 1'b0;
    el_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("rst_tvalid", a_tvalid, 0);
    check("rst_wready", a_wready, 2'b00);
    check("rst_outend", a_outend, 0);
    check("rst_tdata", a_tdata, 0);
    check("rst_tlast_tuser", {a_tlast, a_tuser}, 2'b00);
    check("rst_tstrb", a_tstrb, 4'b0111);
    check("rst_tkeep", a_tkeep, 4'b0111);
    check("rst_tid_tdest", {a_tid, a_tdest}, 2'b00);
    check("rst_state", a_state, 0);
    rst = 1'b0;
    tick();

    // Basic frame: one pixel per cycle, no bubble at the block boundary
    a_tready = 1'b1;
    a_en     = 2'b11;
    load_frame_a();
    start_a();
    check("basic_state_active", a_state, 1);
    check("basic_first_wready", a_wready, 2'b01);
    tick();
    check("basic_first_tvalid", a_tvalid, 1);
    check("basic_first_beat", {a_tuser, a_tlast, a_tdata}, {1'b1, 1'b0, 32'd0});
    wait_done_a("basic", 100, n);
    check("basic_cycles", n, 16);

    // Backpressure after beat 0
    load_frame_a();
    start_a();
    tick();
    tick();
    a_tready = 1'b0;
    repeat (5) tick();
    check("bp_wready", a_wready, 2'b00);
    check("bp_tvalid", a_tvalid, 1);
    check("bp_tdata", a_tdata, 1);
    a_tready = 1'b1;
    wait_done_a("bp", 100, n);

    // Ownership: only the non-owning element valid at col 2
    a_en = 2'b01;
    load_frame_a();
    start_a();
    tick();
    tick();
    a_en = 2'b10;
    repeat (3) tick();
    check("own_wready", a_wready, 2'b01);
    check("own_tvalid", a_tvalid, 0);
    check("own_el1_untouched", a_cnt[1], 0);
    a_en = 2'b11;
    wait_done_a("own", 100, n);

    // Spurious control: wvalid in IDLE, UPSTART mid-frame
    repeat (3) tick();
    check("idle_wready", a_wready, 2'b00);
    check("idle_tvalid", a_tvalid, 0);
    check("idle_state", a_state, 0);
    load_frame_a();
    start_a();
    repeat (7) tick();
    a_upstart = 1'b1;
    tick();
    a_upstart = 1'b0;
    check("spur_state_active", a_state, 1);
    wait_done_a("spur", 100, n);

    // Reset mid-frame after 5 beats
    load_frame_a();
    start_a();
    n = 0;
    while (beats_a < 5 && n < 50) begin
      tick();
      n++;
    end
    check("mid_reached_5", beats_a >= 5, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_tvalid", a_tvalid, 0);
    check("mid_rst_wready", a_wready, 2'b00);
    check("mid_rst_state", a_state, 0);
    exp_a.delete();
    tick();
    rst = 1'b0;
    tick();
    load_frame_a();
    start_a();
    tick();
    check("restart_first_beat", {a_tvalid, a_tuser, a_tdata}, {1'b1, 1'b1, 32'd0});
    wait_done_a("restart", 100, n);

    // Single element, 4-pixel rows
    b_en     = 1'b1;
    b_tready = 1'b1;
    load_frame_b();
    start_b();
    check("b_first_wready", b_wready, 1'b1);
    check("b_tstrb", b_tstrb, 4'b0111);
    wait_done_b("b_frame", 100, n);
    check("b_cycles", n, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
